// File: rtl/pe_output_rr.sv
// PE-side output port of the ring router: per-VC round-robin arbitration of
// NUM_CH ring channels into per-VC FIFOs, draining the polarity-selected VC.
module pe_output_rr #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_CH     = 2,
  parameter int BUF_DEPTH  = 2,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         polarity,
  input  logic [NUM_CH-1:0]            req_even,
  input  logic [NUM_CH-1:0]            req_odd,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_even,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_odd,
  output logic [NUM_CH-1:0]            grant_even,
  output logic [NUM_CH-1:0]            grant_odd,
  input  logic                         pero,
  output logic                         peso,
  output logic [DATA_WIDTH-1:0]        pedo,
  output logic [CNT_W-1:0]             occ_even,
  output logic [CNT_W-1:0]             occ_odd
);

  // A one-entry FIFO still needs a 1-bit pointer; it simply never leaves 0.
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int RR_W  = $clog2(NUM_CH);

  // VC index 0 = even, 1 = odd throughout.
  logic [NUM_CH-1:0]            req_w   [2];
  logic [NUM_CH*DATA_WIDTH-1:0] data_w  [2];
  logic [NUM_CH-1:0]            grant_w [2];
  logic [CNT_W-1:0]             occ_w   [2];
  logic [DATA_WIDTH-1:0]        head_w  [2];
  logic                         pop_w   [2];

  assign req_w[0]   = req_even;
  assign req_w[1]   = req_odd;
  assign data_w[0]  = data_even;
  assign data_w[1]  = data_odd;
  assign grant_even = grant_w[0];
  assign grant_odd  = grant_w[1];
  assign occ_even   = occ_w[0];
  assign occ_odd    = occ_w[1];

  // First requester found scanning upward from rr, wrapping modulo NUM_CH.
  function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [RR_W-1:0]   rr);
    logic found;
    int   idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (int'(rr) + off) % NUM_CH;
      if (!found && req[idx]) begin
        rr_pick[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
      logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]      occ_q, occ_d;
      logic [RR_W-1:0]       rr_q, rr_d;
      logic                  full;
      logic                  push;
      logic                  pop;
      logic [DATA_WIDTH-1:0] push_data;

      // Grants look only at the registered occupancy, so a same-cycle pop
      // never opens an extra slot.
      assign full        = (occ_q == CNT_W'(BUF_DEPTH));
      assign grant_w[gi] = full ? '0 : rr_pick(req_w[gi], rr_q);
      assign push        = |grant_w[gi];
      assign pop         = pero && (polarity == 1'(gi)) && (occ_q != '0);

      // Select the granted channel's flit and move rr just past it.
      always_comb begin
        push_data = '0;
        rr_d      = rr_q;
        for (int i = 0; i < NUM_CH; i++) begin
          if (grant_w[gi][i]) begin
            push_data = data_w[gi][i*DATA_WIDTH +: DATA_WIDTH];
            rr_d      = RR_W'((i + 1) % NUM_CH);
          end
        end
      end

      // FIFO pointer and occupancy next-state.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
          wr_ptr_d = (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_d = (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
          occ_d = occ_q + CNT_W'(1);
        end else if (pop && !push) begin
          occ_d = occ_q - CNT_W'(1);
        end
      end

      // Control state; reset discards any buffered flits and ignores grants.
      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          occ_q    <= '0;
          rr_q     <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          occ_q    <= occ_d;
          rr_q     <= rr_d;
        end
      end

      // Flit storage; contents need no reset since occupancy gates reads.
      always_ff @(posedge clk) begin
        if (!rst && push) begin
          mem_q[wr_ptr_q] <= push_data;
        end
      end

      assign occ_w[gi]  = occ_q;
      assign head_w[gi] = mem_q[rd_ptr_q];
      assign pop_w[gi]  = pop;
    end
  endgenerate

  logic                  peso_q, peso_d;
  logic [DATA_WIDTH-1:0] pedo_q, pedo_d;

  // Output stage: capture the drain-VC head on a pop, otherwise hold pedo.
  always_comb begin
    peso_d = pop_w[0] | pop_w[1];
    pedo_d = pedo_q;
    if (pop_w[polarity]) begin
      pedo_d = head_w[polarity];
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      peso_q <= 1'b0;
      pedo_q <= '0;
    end else begin
      peso_q <= peso_d;
      pedo_q <= pedo_d;
    end
  end

  assign peso = peso_q;
  assign pedo = pedo_q;

endmodule
